bubble_sorter: RTL

Buffered in-place sort stage for the sorting datapath. It collects a fixed-size frame of DEPTH unsigned words over a valid/ready input and sorts them in place, one compare-exchange per cycle. It then streams the frame out in ascending order over a valid/ready output. Its internal index counter wraps at DEPTH and that wrap is what sequences the load, sort and drain phases.

---
 rtl/bubble_sorter.sv | 108 ++++++++++
 1 files changed

// File: rtl/bubble_sorter.sv
// Frame-buffered bubble sorter: loads DEPTH words, sorts in place with one
// compare-exchange per cycle, then drains the frame in ascending order.
module bubble_sorter #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_swapped;
    logic [W-1:0]     r_mem [DEPTH];

    logic [IDX_W-1:0] w_idx_nxt;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic             w_swap;
    logic             w_last;
    logic             w_pass_end;
    logic             w_load_acc;
    logic             w_drain_acc;

    assign w_idx_nxt   = r_idx + IDX_W'(1);
    assign w_a         = r_mem[r_idx];
    assign w_b         = r_mem[w_idx_nxt];
    // Strict compare keeps equal words in place.
    assign w_swap      = (r_state == S_SORT) && (w_a > w_b);
    assign w_last      = (r_idx == IDX_W'(DEPTH - 1));
    assign w_pass_end  = (r_idx == IDX_W'(DEPTH - 2));

    assign in_ready    = (r_state == S_LOAD);
    assign out_valid   = (r_state == S_DRAIN);
    assign busy        = (r_state == S_SORT);
    assign out_data    = r_mem[r_idx];
    assign w_load_acc  = in_ready && in_valid;
    assign w_drain_acc = out_valid && out_ready;
    assign done        = w_drain_acc && w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_LOAD;
            r_idx     <= '0;
            r_swapped <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_load_acc) begin
                        r_idx <= w_idx_nxt;
                        if (w_last) begin
                            r_swapped <= 1'b0;
                            r_state   <= S_SORT;
                        end
                    end
                end
                S_SORT: begin
                    if (w_pass_end) begin
                        r_idx     <= '0;
                        r_swapped <= 1'b0;
                        // A swap on the final compare of a pass still forces another pass.
                        if (!(r_swapped || w_swap))
                            r_state <= S_DRAIN;
                    end else begin
                        r_idx <= w_idx_nxt;
                        if (w_swap)
                            r_swapped <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_acc) begin
                        r_idx <= w_idx_nxt;
                        if (w_last)
                            r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Buffer is not reset; contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_load_acc) begin
                r_mem[r_idx] <= in_data;
            end else if (w_swap) begin
                r_mem[r_idx]     <= w_b;
                r_mem[w_idx_nxt] <= w_a;
            end
        end
    end

endmodule
